// File: rtl/image_stream_source.sv
module image_stream_source #(
  parameter int    I_WIDTH      = 8,
  parameter int    CHANNELS_IN  = 3,
  parameter int    IMAGE_WIDTH  = 64,
  parameter int    IMAGE_HEIGHT = 32,
  parameter string FILEPATH     = "",
  localparam int   TOTAL        = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int   ADDR_W       = $clog2(TOTAL),
  localparam int   PIX_W        = CHANNELS_IN * I_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  input  logic              hold,
  output logic [PIX_W-1:0]  output_data,
  output logic              clk_en_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pixel_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  logic [PIX_W-1:0] mem [TOTAL];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              clk_en_q, clk_en_d;
  logic              done_q, done_d;
  logic [PIX_W-1:0]  data_q;
  logic              rd_en;
  logic              wr_fire;
  logic              last_addr;

  assign last_addr = ({1'b0, addr_q} == (ADDR_W+1)'(TOTAL - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      if (rd_en) data_q <= mem[addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (!hold && last_addr) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_fire  = rst_n && (state_q == S_IDLE) && wr_en
               && ({1'b0, wr_addr} < (ADDR_W+1)'(TOTAL));
    rd_en    = (state_q == S_STREAM) && !hold;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    clk_en_d = 1'b0;
    done_d   = (state_q == S_DONE);
    if ((state_q == S_IDLE) && start) begin
      addr_d = '0;
      cnt_d  = '0;
    end
    if (rd_en) begin
      addr_d   = addr_q + ADDR_W'(1);
      cnt_d    = cnt_q + (ADDR_W+1)'(1);
      clk_en_d = 1'b1;
    end
  end

  assign output_data = data_q;
  assign clk_en_out  = clk_en_q;
  assign busy        = (state_q == S_STREAM);
  assign done        = done_q;
  assign pixel_count = cnt_q;

endmodule

// File: tb/tb_image_stream_source.sv
// Scoreboard bench for image_stream_source: expected pixels are queued at start and
// popped whenever clk_en_out presents a pixel.
module tb_image_stream_source;
    localparam int I_WIDTH    = 8;
    localparam int CH         = 3;
    localparam int W          = 64;
    localparam int H          = 32;
    localparam int TOTAL      = W * H;
    localparam int ADDR_W     = $clog2(TOTAL);
    localparam int PIX_W      = CH * I_WIDTH;
    localparam int HOLD_EXTRA = TOTAL / 3;
    localparam int DONE_J     = TOTAL + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [PIX_W-1:0]  wr_data = '0;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [PIX_W-1:0]  output_data;
    logic              clk_en_out;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   pixel_count;

    image_stream_source #(
        .I_WIDTH(I_WIDTH), .CHANNELS_IN(CH), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILEPATH("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .hold(hold), .output_data(output_data), .clk_en_out(clk_en_out),
        .busy(busy), .done(done), .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    int               tests_run = 0;
    int               tests_failed = 0;
    int               emitted = 0;
    logic [PIX_W-1:0] model_mem [TOTAL];
    logic [PIX_W-1:0] sb_q [$];
    logic [PIX_W-1:0] exp_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel monitor: every presented pixel must be the next queued one
    always @(negedge clk) begin
        if (clk_en_out === 1'b1) begin
            emitted++;
            if (sb_q.size() == 0) begin
                check("sb_extra_pixel", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_pix = sb_q.pop_front();
                check("pixel", 32'(output_data), 32'(exp_pix));
                check("pixel_count", 32'(pixel_count), 32'(emitted));
            end
        end
    end

    task automatic run_stream(input bit hold_mode, input int inject_j, input int rst_j,
                              input bit sw_en, input logic [ADDR_W-1:0] sw_addr,
                              input logic [PIX_W-1:0] sw_data, input int exp_j);
        bit h;
        bit fin;
        if (sw_en) model_mem[sw_addr] = sw_data;
        for (int i = 0; i < TOTAL; i++) sb_q.push_back(model_mem[i]);
        emitted = 0;
        start   = 1'b1;
        wr_en   = sw_en;
        wr_addr = sw_addr;
        wr_data = sw_data;
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        fin   = 1'b0;
        for (int j = 1; j <= 4000 && !fin; j++) begin
            h    = hold_mode && (j % 4 == 0);
            hold = h;
            if (j == inject_j) begin
                wr_en = 1'b1; wr_addr = ADDR_W'(100); wr_data = '1; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            rst_n = (j != rst_j);
            @(posedge clk); #1;
            if (j == rst_j) begin
                check("rst_clk_en", 32'(clk_en_out), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_pixel_count", 32'(pixel_count), 32'd0);
                check("rst_emitted", 32'(emitted), 32'd50);
                fin = 1'b1;
            end else if (done === 1'b1) begin
                check("done_latency", 32'(j), 32'(exp_j));
                check("done_clk_en", 32'(clk_en_out), 32'd0);
                check("done_busy", 32'(busy), 32'd0);
                check("done_pixel_count", 32'(pixel_count), 32'(TOTAL));
                check("sb_left", 32'(sb_q.size()), 32'd0);
                fin = 1'b1;
            end else begin
                check("clk_en", 32'(clk_en_out), 32'(!h));
                if (j == 1) check("busy", 32'(busy), 32'd1);
            end
        end
        hold  = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;
        if (!fin) check("done_timeout", 32'(done), 32'd1);
        if (rst_j > 0) begin
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                check("post_rst_done", 32'(done), 32'd0);
                check("post_rst_clk_en", 32'(clk_en_out), 32'd0);
            end
            sb_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_output_data", 32'(output_data), 32'd0);
        check("reset_clk_en", 32'(clk_en_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_pixel_count", 32'(pixel_count), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < TOTAL; i++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = PIX_W'(i);
            model_mem[i] = PIX_W'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;

        // Plain stream, then a held stream started back-to-back in the IDLE cycle after done
        run_stream(1'b0, 0, 0, 1'b0, '0, '0, DONE_J);
        run_stream(1'b1, 0, 0, 1'b0, '0, '0, DONE_J + HOLD_EXTRA);

        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = ADDR_W'(5); wr_data = 24'hABCDEF;
        model_mem[5] = 24'hABCDEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        run_stream(1'b0, 0, 0, 1'b0, '0, '0, DONE_J);

        run_stream(1'b0, 0, 0, 1'b1, ADDR_W'(0), 24'h123456, DONE_J);
        run_stream(1'b0, 30, 0, 1'b0, '0, '0, DONE_J);
        run_stream(1'b0, 0, 51, 1'b0, '0, '0, 0);
        run_stream(1'b0, 0, 0, 1'b0, '0, '0, DONE_J);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
